matmul_tile_engine: RTL

MATMUL_TILE_ENGINE -- requirements
Module: matmul_tile_engine

---
 rtl/matmul_tile_engine_pkg.sv | 21 ++
 rtl/matmul_tile_engine_if.sv | 30 +++
 rtl/matmul_tile_engine_mac_lane.sv | 60 ++++++
 rtl/matmul_tile_engine.sv | 80 ++++++++
 4 files changed

// File: rtl/matmul_tile_engine_pkg.sv
// Shared FSM encoding, default parameters and accumulator sizing for the tile engine.
package matmul_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_OUTPUT_WIDTH = 16;
    localparam int DEF_MAC_NUM      = 8;
    localparam int DEF_K_MAX        = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Wide enough that K_MAX full-scale products can never overflow.
    function automatic int acc_width(input int data_w, input int weight_w, input int k_max);
        return data_w + weight_w + $clog2(k_max);
    endfunction

endpackage

// File: rtl/matmul_tile_engine_if.sv
// Tile engine control, input-beat and result handshake bundle.
interface matmul_tile_engine_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int MAC_NUM      = 8,
    parameter int K_MAX        = 64
);
    logic                             start_i;
    logic [$clog2(K_MAX):0]           k_len_i;
    logic                             s_valid_i;
    logic                             s_ready_o;
    logic [DATA_WIDTH*MAC_NUM-1:0]    din_i;
    logic [WEIGHT_WIDTH-1:0]          win_i;
    logic                             m_valid_o;
    logic                             m_ready_i;
    logic [OUTPUT_WIDTH*MAC_NUM-1:0]  matmul_o;
    logic                             busy_o;
    logic                             done_o;

    modport slave (
        input  start_i, k_len_i, s_valid_i, din_i, win_i, m_ready_i,
        output s_ready_o, m_valid_o, matmul_o, busy_o, done_o
    );

    modport master (
        output start_i, k_len_i, s_valid_i, din_i, win_i, m_ready_i,
        input  s_ready_o, m_valid_o, matmul_o, busy_o, done_o
    );
endinterface

// File: rtl/matmul_tile_engine_mac_lane.sv
// One signed multiply-accumulate lane with registered output reduction.
// Define MATMUL_SAT_EN for saturating reduction; otherwise the low bits wrap.
module mac_lane
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int K_MAX        = DEF_K_MAX
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           clear_i,
    input  logic                           en_i,
    input  logic                           load_i,
    input  logic signed [DATA_WIDTH-1:0]   din_i,
    input  logic signed [WEIGHT_WIDTH-1:0] win_i,
    output logic [OUTPUT_WIDTH-1:0]        result_o
);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, WEIGHT_WIDTH, K_MAX);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (OUTPUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (OUTPUT_WIDTH - 1)));

    logic signed [DATA_WIDTH+WEIGHT_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]               acc_q;
    logic signed [ACC_WIDTH-1:0]               acc_next;
    logic [OUTPUT_WIDTH-1:0]                   reduced;

    assign product  = din_i * win_i;
    assign acc_next = acc_q + ACC_WIDTH'(product);

    // Reduction is taken from acc_next so the result is ready the cycle after the last beat.
    always_comb begin
        reduced = acc_next[OUTPUT_WIDTH-1:0];
`ifdef MATMUL_SAT_EN
        if (acc_next > SAT_MAX) begin
            reduced = SAT_MAX[OUTPUT_WIDTH-1:0];
        end else if (acc_next < SAT_MIN) begin
            reduced = SAT_MIN[OUTPUT_WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q    <= '0;
            result_o <= '0;
        end else begin
            if (clear_i) begin
                acc_q <= '0;
            end else if (en_i) begin
                acc_q <= acc_next;
            end
            if (load_i) begin
                result_o <= reduced;
            end
        end
    end

endmodule

// File: rtl/matmul_tile_engine.sv
// Tile engine: broadcast-weight MAC array sequenced by an IDLE/ACCUM/OUT FSM.
// MATMUL_SAT_EN selects saturating (defined) or wrapping (default) output lanes.
module matmul_tile_engine
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int MAC_NUM      = DEF_MAC_NUM,
    parameter int K_MAX        = DEF_K_MAX
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    matmul_tile_engine_if.slave   bus
);
    localparam int CW = $clog2(K_MAX) + 1;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, depth_q, depth_clamped;
    logic                            start_ok, beat, last_beat, done_q;
    logic [OUTPUT_WIDTH*MAC_NUM-1:0] lanes_w;

    assign start_ok      = (state_q == ST_IDLE) && bus.start_i && (bus.k_len_i != '0);
    assign depth_clamped = (bus.k_len_i > CW'(K_MAX)) ? CW'(K_MAX) : bus.k_len_i;
    assign beat          = (state_q == ST_ACCUM) && bus.s_valid_i;
    assign last_beat     = beat && ((cnt_q + CW'(1)) == depth_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok)      state_d = ST_ACCUM;
            ST_ACCUM: if (last_beat)     state_d = ST_OUT;
            ST_OUT:   if (bus.m_ready_i) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            depth_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_OUT) && bus.m_ready_i;
            if (start_ok) begin
                cnt_q   <= '0;
                depth_q <= depth_clamped;
            end else if (beat) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.s_ready_o = (state_q == ST_ACCUM);
    assign bus.m_valid_o = (state_q == ST_OUT);
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.done_o    = done_q;
    assign bus.matmul_o  = lanes_w;

    for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .OUTPUT_WIDTH (OUTPUT_WIDTH),
            .K_MAX        (K_MAX)
        ) u_lane (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .clear_i  (start_ok),
            .en_i     (beat),
            .load_i   (last_beat),
            .din_i    (bus.din_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .win_i    (bus.win_i),
            .result_o (lanes_w[i*OUTPUT_WIDTH +: OUTPUT_WIDTH])
        );
    end

endmodule
